// File: rtl/dm_responder.sv
// Data-memory responder for the CPU M-stage port: byte-enabled stores, combinational reads,
// post-reset clear sweep. Define DM_TRACE_EN to build the committed-store trace FIFO.
module dm_responder #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned TRACE_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [3:0]  m_data_byteen,
    input  logic [31:0] m_data_wdata,
    input  logic [31:0] m_inst_addr,
    output logic [31:0] m_data_rdata,
    output logic        mem_ready,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data,
    output logic        trace_ovf,
    output logic        access_err
);

    localparam int unsigned WORDS = 1 << ADDR_WIDTH;

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   sweep;
    logic [31:0]             mem [WORDS];

    logic [31:0]             off;
    logic                    in_range;
    logic [ADDR_WIDTH-1:0]   idx;
    logic [31:0]             cur;
    logic [31:0]             merged;
    logic                    store_req;
    logic                    store_ok;

    assign off       = m_data_addr - BASE_ADDR;
    assign in_range  = (off >> (ADDR_WIDTH + 2)) == 32'd0;
    assign idx       = off[ADDR_WIDTH+1:2];
    assign cur       = mem[idx];
    assign store_req = (state == S_RUN) && (m_data_byteen != 4'b0000);
    assign store_ok  = store_req && in_range;

    // Stored data becomes visible only after the edge, since the CPU samples rdata at that edge.
    assign m_data_rdata = ((state == S_RUN) && in_range) ? cur : 32'd0;

    always_comb begin
        merged = cur;
        for (int i = 0; i < 4; i++) begin
            if (m_data_byteen[i]) merged[8*i +: 8] = m_data_wdata[8*i +: 8];
        end
    end

    // Sweep/run control; a reset mid-sweep restarts the clear from word 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_CLEAR;
            sweep      <= '0;
            mem_ready  <= 1'b0;
            access_err <= 1'b0;
        end else begin
            case (state)
                S_CLEAR: begin
                    sweep <= sweep + ADDR_WIDTH'(1);
                    if (sweep == '1) begin
                        state     <= S_RUN;
                        mem_ready <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (store_req && !in_range) access_err <= 1'b1;
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            mem[sweep] <= 32'd0;
        end else if (store_ok) begin
            mem[idx] <= merged;
        end
    end

`ifdef DM_TRACE_EN
    localparam int unsigned PW = $clog2(TRACE_DEPTH);

    logic [31:0] f_pc   [TRACE_DEPTH];
    logic [31:0] f_addr [TRACE_DEPTH];
    logic [31:0] f_data [TRACE_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_next;
    logic [PW:0]   count;
    logic [PW:0]   remain;
    logic [PW:0]   count_next;
    logic          pop;
    logic          full;
    logic          push;
    logic [31:0]   push_addr;

    assign pop       = trace_valid && trace_ready;
    assign full      = count == (PW+1)'(TRACE_DEPTH);
    assign push      = store_ok && (!full || pop);
    assign push_addr = BASE_ADDR + (32'(idx) << 2);

    always_comb begin
        rd_next    = pop ? rd_ptr + PW'(1) : rd_ptr;
        remain     = count - (PW+1)'(pop);
        count_next = remain + (PW+1)'(push);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            f_pc[wr_ptr]   <= m_inst_addr;
            f_addr[wr_ptr] <= push_addr;
            f_data[wr_ptr] <= merged;
        end
    end

    // Head registers are reloaded from the entry that will be at the head after this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            trace_valid <= 1'b0;
            trace_pc    <= 32'd0;
            trace_addr  <= 32'd0;
            trace_data  <= 32'd0;
            trace_ovf   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            rd_ptr      <= rd_next;
            count       <= count_next;
            trace_valid <= count_next != '0;
            if (store_ok && full && !pop) trace_ovf <= 1'b1;
            if (remain != '0) begin
                trace_pc   <= f_pc[rd_next];
                trace_addr <= f_addr[rd_next];
                trace_data <= f_data[rd_next];
            end else if (push) begin
                trace_pc   <= m_inst_addr;
                trace_addr <= push_addr;
                trace_data <= merged;
            end
        end
    end
`else
    logic unused_trace;

    assign unused_trace = ^{trace_ready, m_inst_addr};
    assign trace_valid  = 1'b0;
    assign trace_pc     = 32'd0;
    assign trace_addr   = 32'd0;
    assign trace_data   = 32'd0;
    assign trace_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: directed steps plus randomized stores against a word-array and
// queue reference model. Trace expectations follow DM_TRACE_EN.
module tb_dm_responder;

    localparam int unsigned AW    = 12;
    localparam int unsigned WORDS = 1 << AW;
    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] m_data_addr = 32'd0;
    logic [3:0]  m_data_byteen = 4'd0;
    logic [31:0] m_data_wdata = 32'd0;
    logic [31:0] m_inst_addr = 32'd0;
    logic        trace_ready = 1'b0;
    logic [31:0] m_data_rdata;
    logic        mem_ready;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;
    logic        trace_ovf;
    logic        access_err;

    always #5 clk = ~clk;

    dm_responder #(
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (BASE),
        .TRACE_DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .m_data_addr  (m_data_addr),
        .m_data_byteen(m_data_byteen),
        .m_data_wdata (m_data_wdata),
        .m_inst_addr  (m_inst_addr),
        .m_data_rdata (m_data_rdata),
        .mem_ready    (mem_ready),
        .trace_valid  (trace_valid),
        .trace_ready  (trace_ready),
        .trace_pc     (trace_pc),
        .trace_addr   (trace_addr),
        .trace_data   (trace_data),
        .trace_ovf    (trace_ovf),
        .access_err   (access_err)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] ref_mem [WORDS];
    ent_t        q[$];
    bit          ref_ovf;
    bit          ref_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (off >= 32'(4 * WORDS)) return 32'd0;
        return ref_mem[off[AW+1:2]];
    endfunction

    task automatic check_state(input string tag);
        chk({tag, " mem_ready"}, 32'(mem_ready), 32'd1);
        chk({tag, " access_err"}, 32'(access_err), 32'(ref_err));
        chk({tag, " trace_ovf"}, 32'(trace_ovf), 32'(ref_ovf));
`ifdef DM_TRACE_EN
        chk({tag, " trace_valid"}, 32'(trace_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk({tag, " trace_pc"}, trace_pc, q[0].pc);
            chk({tag, " trace_addr"}, trace_addr, q[0].addr);
            chk({tag, " trace_data"}, trace_data, q[0].data);
        end
`else
        chk({tag, " trace_valid"}, 32'(trace_valid), 32'd0);
        chk({tag, " trace_head"}, trace_pc | trace_addr | trace_data, 32'd0);
`endif
    endtask

    // One bus cycle: caller sits at a negedge; read is checked before the edge, state after it.
    task automatic step(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                        input logic [31:0] pc, input bit rdy, input string tag);
        logic [31:0] off;
        logic [31:0] w;
        m_data_addr   = a;
        m_data_byteen = be;
        m_data_wdata  = d;
        m_inst_addr   = pc;
        trace_ready   = rdy;
        #1;
        chk({tag, " rdata"}, m_data_rdata, ref_read(a));
`ifdef DM_TRACE_EN
        if (rdy && q.size() != 0) q.delete(0);
`endif
        off = a - BASE;
        if (be != 4'd0) begin
            if (off < 32'(4 * WORDS)) begin
                w = ref_mem[off[AW+1:2]];
                for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = d[8*i +: 8];
                ref_mem[off[AW+1:2]] = w;
`ifdef DM_TRACE_EN
                if (q.size() < DEPTH) q.push_back('{pc, BASE + (off & ~32'd3), w});
                else ref_ovf = 1'b1;
`endif
            end else begin
                ref_err = 1'b1;
            end
        end
        @(negedge clk);
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset         = 1'b0;
        m_data_addr   = 32'h0000_0010;
        m_data_byteen = 4'd0;
        trace_ready   = 1'b0;
        repeat (3) @(negedge clk);
        chk({tag, " rst mem_ready"}, 32'(mem_ready), 32'd0);
        chk({tag, " rst trace_valid"}, 32'(trace_valid), 32'd0);
        chk({tag, " rst trace_ovf"}, 32'(trace_ovf), 32'd0);
        chk({tag, " rst access_err"}, 32'(access_err), 32'd0);
        chk({tag, " rst trace_head"}, trace_pc | trace_addr | trace_data, 32'd0);
        chk({tag, " rst rdata"}, m_data_rdata, 32'd0);
        foreach (ref_mem[i]) ref_mem[i] = 32'd0;
        q.delete();
        ref_ovf = 1'b0;
        ref_err = 1'b0;
        reset = 1'b1;
    endtask

    // Counts cycles with mem_ready low while a store is held on the bus (must be ignored).
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        m_data_addr   = 32'h0000_0010;
        m_data_byteen = 4'hF;
        m_data_wdata  = 32'hFFFF_FFFF;
        m_inst_addr   = 32'h0000_1234;
        while (n < 5000) begin
            @(posedge clk);
            #1;
            n++;
            if (mem_ready) break;
            if (n == 100) chk({tag, " sweep rdata"}, m_data_rdata, 32'd0);
        end
        m_data_byteen = 4'd0;
        chk({tag, " clear cycles"}, 32'(n), 32'(WORDS));
        @(negedge clk);
        check_state({tag, " ready"});
        chk({tag, " read 0x10"}, m_data_rdata, 32'd0);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < int'(DEPTH) + 1; k++) step(32'h0000_0008, 4'd0, 32'd0, 32'd0, 1'b1, tag);
    endtask

    initial begin
        do_reset("boot");
        wait_ready("boot");

        step(32'h0000_0008, 4'hF, 32'hDEAD_BEEF, 32'h0000_3000, 1'b0, "t2 store");
        step(32'h0000_0008, 4'h0, 32'd0, 32'd0, 1'b0, "t2 read");
        chk("t2 rdata const", m_data_rdata, 32'hDEAD_BEEF);
        step(32'h0000_000A, 4'b0100, 32'h0055_0000, 32'h0000_3004, 1'b0, "t3 store");
        step(32'h0000_0008, 4'h0, 32'd0, 32'd0, 1'b1, "t3 read");
        chk("t3 rdata const", m_data_rdata, 32'hDE55_BEEF);
        drain("t3 drain");

        for (int k = 0; k < 9; k++)
            step(32'h0000_0100 + 32'(4 * k), 4'hF, $urandom, 32'h0000_4000 + 32'(4 * k), 1'b0, "t4 store");
        for (int k = 0; k < 9; k++)
            step(32'h0000_0100 + 32'(4 * k), 4'h0, 32'd0, 32'd0, 1'b0, "t4 read");
        drain("t4 drain");

        for (int k = 0; k < 80; k++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
            step(a, 4'($urandom_range(0, 15)), $urandom, 32'h0000_5000 + 32'(4 * k),
                 bit'($urandom_range(0, 2) == 0), "rand");
        end
        drain("rand drain");

        do_reset("mid");
        repeat (50) @(negedge clk);
        do_reset("restart");
        wait_ready("restart");

        for (int k = 0; k < 8; k++)
            step(32'h0000_0200 + 32'(4 * k), 4'hF, $urandom, 32'h0000_6000 + 32'(4 * k), 1'b0, "t5 fill");
        step(32'h0000_0220, 4'hF, $urandom, 32'h0000_6020, 1'b1, "t5 pushpop");
        step(32'h0000_0224, 4'hF, $urandom, 32'h0000_6024, 1'b0, "t5 full");
        drain("t5 drain");

        step(32'h0000_4000, 4'hF, $urandom, 32'h0000_7000, 1'b0, "t6 oor store");
        chk("t6 access_err", 32'(access_err), 32'd1);
        step(32'h0000_4000, 4'h0, 32'd0, 32'd0, 1'b0, "t6 oor read");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder on the memory side of the CPU's M-stage data port. It consumes m_data_addr, m_data_byteen, m_data_wdata and m_inst_addr, and returns m_data_rdata.
- Performs byte-enabled stores and combinational word reads.
- Clears its array with a post-reset sweep FSM.
- Buffers every committed store in a trace FIFO with a valid/ready drain port, used by the bench for store-log comparison.

Parameters:
- ADDR_WIDTH, 12, word-index bits; capacity is 2^ADDR_WIDTH 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.
- TRACE_DEPTH, 8, trace FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- m_data_addr  input  32  byte address from the CPU M stage.
- m_data_byteen  input  4  byte lane write enables; 4'b0000 means no store.
- m_data_wdata  input  32  lane-aligned store data.
- m_inst_addr  input  32  PC of the instruction in the M stage.
- m_data_rdata  output  32  word read data.
- mem_ready  output  1  high once the clear sweep is done.
- trace_valid  output  1  FIFO head valid.
- trace_ready  input  1  bench accepts the head.
- trace_pc  output  32  PC of the head store.
- trace_addr  output  32  word-aligned address of the head store (addr[1:0]=0).
- trace_data  output  32  full word after the merge.
- trace_ovf  output  1  sticky: a store was dropped because the FIFO was full.
- access_err  output  1  sticky: a store targeted an out-of-range address.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to CLEAR with the sweep index at 0.
  - FIFO pointers and count are 0.
  - mem_ready, trace_valid, trace_ovf and access_err are 0.
  - trace_pc, trace_addr and trace_data are 0.
  - Array contents are not reset directly; the sweep clears them.
- CLEAR state:
  - Each cycle writes 0 to the word at the sweep index, then increments the index.
  - On the edge that writes index 2^ADDR_WIDTH-1, go to RUN; mem_ready is 1 from the next cycle.
  - In CLEAR: m_data_rdata=0, stores are ignored (no trace push, no access_err).
  - Reset asserted mid-sweep restarts the sweep at index 0.
- RUN state, offset and range:
  - off = m_data_addr - BASE_ADDR.
  - In range iff off < 4*2^ADDR_WIDTH.
  - Word index = off[ADDR_WIDTH+1:2]; off[1:0] is ignored, and the lane pattern comes solely from byteen.
- RUN state, reads:
  - m_data_rdata = mem[index], combinational.
  - Out-of-range reads return 0.
  - A same-cycle store is not visible until the next cycle, because the CPU captures rdata at the same edge.
- RUN state, stores:
  - When byteen!=0 and in range, on the rising edge write mem[index] byte lane i := wdata[8i+7:8i] for each byteen[i]=1; other lanes are kept.
  - Push {m_inst_addr, BASE_ADDR+4*index, merged word} into the FIFO.
- RUN state, out-of-range stores: byteen!=0 and out of range means no write, no push, and access_err is set.
- FIFO:
  - Pop on trace_valid & trace_ready.
  - trace_* always show the head entry and are registered (no combinational path from the m_* inputs).
  - A push into an empty FIFO shows trace_valid=1 on the cycle after the edge.
  - Push and pop in the same cycle with count=TRACE_DEPTH: both take effect, no drop.
  - Push with count=TRACE_DEPTH and no pop: the entry is dropped, trace_ovf is set, and the array write still happens.
  - Pointers wrap modulo TRACE_DEPTH.
  - trace_ovf and access_err clear only on reset.
- Back-to-back stores to the same word on consecutive cycles merge cumulatively; each trace entry carries the word as it stands after its own store.

Optional Feature:
- Macro DM_TRACE_EN.
- When defined: the trace FIFO and trace ports behave as above.
- When undefined: no FIFO is built. trace_valid, trace_pc, trace_addr, trace_data and trace_ovf are tied to 0, trace_ready is ignored, and array and read behaviour are unchanged.

Test Plan:
1. Reset low 3 cycles, then high. Required: mem_ready=0 for exactly 4096 cycles (ADDR_WIDTH=12), then 1; a read of 0x0000_0010 returns 0.
2. After ready, store byteen=4'b1111, addr=0x0000_0008, wdata=0xDEADBEEF, pc=0x0000_3000. Required: next-cycle rdata at 0x8 is 0xDEADBEEF; the trace head is {0x3000, 0x8, 0xDEADBEEF}.
3. Store byteen=4'b0100, addr=0x0000_000A, wdata=0x0055_0000. Required: the word at 0x8 becomes 0xDE55BEEF; the trace shows addr 0x8, data 0xDE55BEEF.
4. trace_ready=0, then 9 consecutive full-word stores with TRACE_DEPTH=8. Required: 8 entries are held, trace_ovf=1, all 9 array writes land, and the drained order matches the store order.
5. FIFO full with a simultaneous push and trace_ready=1. Required: count stays 8 and trace_ovf stays 0.
6. Store to 0x0000_4000 (out of range) with byteen=4'b1111. Required: access_err=1, no trace push, and a read of 0x4000 returns 0.
